// File: rtl/sort_pkg.sv
// sort_pkg: shared definitions for the RAM bubble-sort engine.
//   - sort_state_e : controller state encoding
//   - RD_LAT_MIN / RD_LAT_MAX : supported RAM read-latency range
//   - LAT_CNT_W    : width of the read-latency counter
//   - lat_terminal : last value of the read-latency counter for a given latency
package sort_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_PASS_END = 3'd3,
    ST_DONE     = 3'd4
  } sort_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Counter only has to hold 0 .. RD_LAT_MAX-1.
  localparam int LAT_CNT_W  = 2;

  // Terminal count of the READ phase. Out-of-range latencies are clamped so
  // the counter can never run past its width.
  function automatic logic [LAT_CNT_W-1:0] lat_terminal(input int rd_latency);
    int clamped;
    if (rd_latency < RD_LAT_MIN) begin
      clamped = RD_LAT_MIN;
    end else if (rd_latency > RD_LAT_MAX) begin
      clamped = RD_LAT_MAX;
    end else begin
      clamped = rd_latency;
    end
    return LAT_CNT_W'(clamped - 1);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// sort_cmp_swap: combinational compare/exchange decision for one element pair.
// Ports:
//   a, b       - element at the lower / higher address (unsigned)
//   descending - 1: larger values go first, 0: smaller values go first
//   swap       - pair is out of order; equal values never swap
//   lo_out     - value that belongs at the lower address after the decision
//   hi_out     - value that belongs at the higher address after the decision
module sort_cmp_swap #(
  parameter int DWIDTH = 10
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  input  logic              descending,
  output logic              swap,
  output logic [DWIDTH-1:0] lo_out,
  output logic [DWIDTH-1:0] hi_out
);

  // Strict compare in the requested direction, then route the pair.
  always_comb begin
    swap   = 1'b0;
    lo_out = a;
    hi_out = b;
    if (descending) begin
      swap = (a < b);
    end else begin
      swap = (a > b);
    end
    if (swap) begin
      lo_out = b;
      hi_out = a;
    end else begin
      lo_out = a;
      hi_out = b;
    end
  end

endmodule

// File: rtl/ram_sort_engine.sv
// ram_sort_engine: in-place bubble sort of an external dual-port RAM.
// Ports:
//   clk_i, srst_i            - clock, synchronous active-high reset
//   start_i, len_i,
//   descending_i             - sort request; length and order captured on accept
//   address_a_o/address_b_o  - RAM addresses of the pair j / j+1
//   data_a_o/data_b_o,
//   wren_a_o/wren_b_o        - RAM write port, active only for an actual swap
//   q_a_i/q_b_i              - RAM read data, RD_LATENCY clocks after the address
//   busy_o                   - sort in progress
//   done_o                   - one-cycle completion pulse
//   swaps_o                  - swap total of the last completed sort
module ram_sort_engine
  import sort_pkg::*;
#(
  parameter int DWIDTH     = 10,
  parameter int ADDR_SZ    = 10,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 start_i,
  input  logic [ADDR_SZ:0]     len_i,
  input  logic                 descending_i,
  output logic [ADDR_SZ-1:0]   address_a_o,
  output logic [ADDR_SZ-1:0]   address_b_o,
  output logic [DWIDTH-1:0]    data_a_o,
  output logic [DWIDTH-1:0]    data_b_o,
  output logic                 wren_a_o,
  output logic                 wren_b_o,
  input  logic [DWIDTH-1:0]    q_a_i,
  input  logic [DWIDTH-1:0]    q_b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ADDR_SZ*2:0]   swaps_o
);

  localparam int SW_W = 2 * ADDR_SZ + 1;
  localparam logic [LAT_CNT_W-1:0] LAT_LAST = lat_terminal(RD_LATENCY);

  sort_state_e            state_r;
  logic                   desc_r;
  logic [ADDR_SZ-1:0]     j_r;
  logic [ADDR_SZ-1:0]     last_r;
  logic [LAT_CNT_W-1:0]   lat_cnt_r;
  logic [SW_W-1:0]        swap_cnt_r;
  logic                   swapped_r;

  logic                   swap_s;
  logic [DWIDTH-1:0]      lo_s;
  logic [DWIDTH-1:0]      hi_s;
  logic [ADDR_SZ:0]       j_next_s;
  logic                   more_s;
  logic                   in_write_s;

  // j+1 is formed one bit wider so the "more pairs in this pass" test is
  // exact even for a full 2**ADDR_SZ element RAM.
  assign j_next_s   = {1'b0, j_r} + {{ADDR_SZ{1'b0}}, 1'b1};
  assign more_s     = (j_next_s < {1'b0, last_r});
  assign in_write_s = (state_r == ST_WRITE);

  sort_cmp_swap #(
    .DWIDTH (DWIDTH)
  ) u_cmp (
    .a          (q_a_i),
    .b          (q_b_i),
    .descending (desc_r),
    .swap       (swap_s),
    .lo_out     (lo_s),
    .hi_out     (hi_s)
  );

  // The read data only becomes valid in the WRITE cycle itself, so the write
  // port has to be a registered-state gate over the live compare result.
  assign wren_a_o = in_write_s & swap_s;
  assign wren_b_o = in_write_s & swap_s;
  assign data_a_o = lo_s;
  assign data_b_o = hi_s;

  // Sort controller: state, pair index, pass bound and registered outputs.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_r     <= ST_IDLE;
      desc_r      <= 1'b0;
      j_r         <= '0;
      last_r      <= '0;
      lat_cnt_r   <= '0;
      swap_cnt_r  <= '0;
      swapped_r   <= 1'b0;
      address_a_o <= '0;
      address_b_o <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      swaps_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            desc_r     <= descending_i;
            swap_cnt_r <= '0;
            swapped_r  <= 1'b0;
            busy_o     <= 1'b1;
            j_r        <= '0;
            lat_cnt_r  <= '0;
            last_r     <= ADDR_SZ'(len_i - (ADDR_SZ + 1)'(1));
            if (len_i < (ADDR_SZ + 1)'(2)) begin
              // Nothing to order: finish without touching the RAM.
              state_r <= ST_DONE;
            end else begin
              address_a_o <= '0;
              address_b_o <= ADDR_SZ'(1);
              state_r     <= ST_READ;
            end
          end
        end

        ST_READ: begin
          if (lat_cnt_r == LAT_LAST) begin
            lat_cnt_r <= '0;
            state_r   <= ST_WRITE;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_CNT_W'(1);
          end
        end

        ST_WRITE: begin
          if (swap_s) begin
            swap_cnt_r <= swap_cnt_r + SW_W'(1);
            swapped_r  <= 1'b1;
          end
          if (more_s) begin
            j_r         <= j_next_s[ADDR_SZ-1:0];
            address_a_o <= j_next_s[ADDR_SZ-1:0];
            address_b_o <= j_r + ADDR_SZ'(2);
            state_r     <= ST_READ;
          end else begin
            state_r <= ST_PASS_END;
          end
        end

        ST_PASS_END: begin
          // A clean pass, or only one pair left, means the array is ordered.
          if (!swapped_r || (last_r == ADDR_SZ'(1))) begin
            state_r <= ST_DONE;
          end else begin
            last_r      <= last_r - ADDR_SZ'(1);
            j_r         <= '0;
            swapped_r   <= 1'b0;
            address_a_o <= '0;
            address_b_o <= ADDR_SZ'(1);
            state_r     <= ST_READ;
          end
        end

        ST_DONE: begin
          done_o  <= 1'b1;
          swaps_o <= swap_cnt_r;
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
